gomoku_move_ctrl: RTL and testbench

- Upstream move controller for the 7x7 board stage.
- Turns player button inputs into a cursor position, validates each placement against its own occupancy map, and issues single-cycle load strobes (go, x, y, color) to the board.
- Alternates turns, samples the board's win result after every move, and locks the game on a win or a full board.

---
 rtl/gomoku_move_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_gomoku_move_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gomoku_move_ctrl.sv
// Move controller for the 7x7 gomoku board: button edges drive a cursor, placements are
// validated against a local occupancy map, and accepted moves are strobed to the board.
module gomoku_move_ctrl #(
    parameter int N        = 7,
    parameter int CW       = 3,
    parameter int MAXMOVES = 49
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          btn_left,
    input  logic          btn_right,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic          btn_place,
    input  logic          new_game,
    input  logic [1:0]    game_state,
    output logic          go,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          color,
    output logic [CW-1:0] cur_x,
    output logic [CW-1:0] cur_y,
    output logic          reject,
    output logic          game_over,
    output logic [1:0]    winner,
    output logic [5:0]    move_count,
    output logic          board_clr_n
);
    localparam logic [CW-1:0] C_MAX    = CW'(N - 1);
    localparam logic [CW-1:0] C_CENTER = CW'(N / 2);
    localparam int            CELLS    = N * N;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_ISSUE = 2'd1,
        S_CHECK = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [4:0]       r_prev;
    logic [4:0]       w_edge;
    logic [CW-1:0]    r_cur_x, r_cur_y, w_cur_x_nxt, w_cur_y_nxt;
    logic [CW-1:0]    r_x, r_y, w_x_nxt, w_y_nxt;
    logic             r_color, w_color_nxt;
    logic             r_go, w_go_nxt;
    logic             r_reject, w_reject_nxt;
    logic             r_game_over, w_game_over_nxt;
    logic             r_clr_n, w_clr_n_nxt;
    logic [1:0]       r_winner, w_winner_nxt;
    logic [5:0]       r_move_count, w_move_count_nxt;
    logic [CELLS-1:0] r_occ, w_occ_nxt;
    logic [5:0]       w_idx;

    // Edge vector ordered {left, right, up, down, place}
    assign w_edge = {btn_left, btn_right, btn_up, btn_down, btn_place} & ~r_prev;
    assign w_idx  = 6'(r_cur_x) * 6'(N) + 6'(r_cur_y);

    // Next-state, cursor, occupancy and output decode
    always_comb begin
        w_state_nxt      = r_state;
        w_cur_x_nxt      = r_cur_x;
        w_cur_y_nxt      = r_cur_y;
        w_x_nxt          = r_x;
        w_y_nxt          = r_y;
        w_color_nxt      = r_color;
        w_go_nxt         = 1'b0;
        w_reject_nxt     = 1'b0;
        w_game_over_nxt  = r_game_over;
        w_clr_n_nxt      = 1'b1;
        w_winner_nxt     = r_winner;
        w_move_count_nxt = r_move_count;
        w_occ_nxt        = r_occ;
        if (new_game) begin
            w_state_nxt      = S_WAIT;
            w_cur_x_nxt      = C_CENTER;
            w_cur_y_nxt      = C_CENTER;
            w_color_nxt      = 1'b0;
            w_game_over_nxt  = 1'b0;
            w_clr_n_nxt      = 1'b0;
            w_winner_nxt     = 2'd0;
            w_move_count_nxt = 6'd0;
            w_occ_nxt        = '0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (!r_game_over) begin
                        // Placement sees the cursor as it was before this cycle's moves
                        if (w_edge[0]) begin
                            if (r_occ[w_idx]) begin
                                w_reject_nxt = 1'b1;
                            end else begin
                                w_go_nxt           = 1'b1;
                                w_x_nxt            = r_cur_x;
                                w_y_nxt            = r_cur_y;
                                w_occ_nxt[w_idx]   = 1'b1;
                                w_move_count_nxt   = r_move_count + 6'd1;
                                w_state_nxt        = S_ISSUE;
                            end
                        end else begin
                            w_state_nxt = S_WAIT;
                        end
                        if (w_edge[4]) begin
                            w_cur_x_nxt = (r_cur_x != {CW{1'b0}}) ? r_cur_x - CW'(1) : r_cur_x;
                        end else if (w_edge[3]) begin
                            w_cur_x_nxt = (r_cur_x != C_MAX) ? r_cur_x + CW'(1) : r_cur_x;
                        end else begin
                            w_cur_x_nxt = r_cur_x;
                        end
                        if (w_edge[2]) begin
                            w_cur_y_nxt = (r_cur_y != {CW{1'b0}}) ? r_cur_y - CW'(1) : r_cur_y;
                        end else if (w_edge[1]) begin
                            w_cur_y_nxt = (r_cur_y != C_MAX) ? r_cur_y + CW'(1) : r_cur_y;
                        end else begin
                            w_cur_y_nxt = r_cur_y;
                        end
                    end else begin
                        w_state_nxt = S_OVER;
                    end
                end
                S_ISSUE: begin
                    w_state_nxt = S_CHECK;
                end
                S_CHECK: begin
                    if (game_state != 2'd0) begin
                        w_winner_nxt    = game_state;
                        w_game_over_nxt = 1'b1;
                        w_state_nxt     = S_OVER;
                    end else if (r_move_count == 6'(MAXMOVES)) begin
                        w_winner_nxt    = 2'd0;
                        w_game_over_nxt = 1'b1;
                        w_state_nxt     = S_OVER;
                    end else begin
                        w_color_nxt = ~r_color;
                        w_state_nxt = S_WAIT;
                    end
                end
                S_OVER: begin
                    w_state_nxt = S_OVER;
                end
                default: begin
                    w_state_nxt = S_WAIT;
                end
            endcase
        end
    end

    // State and output registers; board clear is held active throughout reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_WAIT;
            r_prev       <= 5'd0;
            r_cur_x      <= C_CENTER;
            r_cur_y      <= C_CENTER;
            r_x          <= {CW{1'b0}};
            r_y          <= {CW{1'b0}};
            r_color      <= 1'b0;
            r_go         <= 1'b0;
            r_reject     <= 1'b0;
            r_game_over  <= 1'b0;
            r_clr_n      <= 1'b0;
            r_winner     <= 2'd0;
            r_move_count <= 6'd0;
            r_occ        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev       <= {btn_left, btn_right, btn_up, btn_down, btn_place};
            r_cur_x      <= w_cur_x_nxt;
            r_cur_y      <= w_cur_y_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_color      <= w_color_nxt;
            r_go         <= w_go_nxt;
            r_reject     <= w_reject_nxt;
            r_game_over  <= w_game_over_nxt;
            r_clr_n      <= w_clr_n_nxt;
            r_winner     <= w_winner_nxt;
            r_move_count <= w_move_count_nxt;
            r_occ        <= w_occ_nxt;
        end
    end

    assign go          = r_go;
    assign x           = r_x;
    assign y           = r_y;
    assign color       = r_color;
    assign cur_x       = r_cur_x;
    assign cur_y       = r_cur_y;
    assign reject      = r_reject;
    assign game_over   = r_game_over;
    assign winner      = r_winner;
    assign move_count  = r_move_count;
    assign board_clr_n = r_clr_n;

endmodule

// File: tb/tb_gomoku_move_ctrl.sv
// Scoreboard bench for gomoku_move_ctrl: a board-level game model predicts strobes and status,
// a negedge monitor pops expected go/reject events as the DUT presents them.
module tb_gomoku_move_ctrl;
    logic       clk, resetn;
    logic       btn_left, btn_right, btn_up, btn_down, btn_place, new_game;
    logic [1:0] game_state;
    logic       go, color, reject, game_over, board_clr_n;
    logic [2:0] x, y, cur_x, cur_y;
    logic [1:0] winner;
    logic [5:0] move_count;

    gomoku_move_ctrl dut (
        .clk(clk), .resetn(resetn),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .btn_place(btn_place), .new_game(new_game), .game_state(game_state),
        .go(go), .x(x), .y(y), .color(color), .cur_x(cur_x), .cur_y(cur_y),
        .reject(reject), .game_over(game_over), .winner(winner),
        .move_count(move_count), .board_clr_n(board_clr_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit is_rej;
        int ex;
        int ey;
        int ec;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    // Game model: board of stones, cursor, turn, result, and the cycles a move is in flight
    bit   occ[7][7];
    int   m_cx, m_cy, m_color, m_cnt, m_win, m_busy;
    bit   m_over, m_clr;
    logic [4:0] m_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        foreach (occ[i, j]) occ[i][j] = 1'b0;
        m_cx = 3; m_cy = 3; m_color = 0; m_cnt = 0; m_win = 0; m_busy = 0;
        m_over = 1'b0; m_clr = 1'b0; m_prev = 5'd0;
        sb.delete();
    endtask

    // One clock of game rules; b = {left, right, up, down, place}
    task automatic model_cycle(input logic [4:0] b, input logic [1:0] gs, input bit ng);
        logic [4:0] e;
        exp_t it;
        e = b & ~m_prev;
        m_prev = b;
        m_clr = 1'b1;
        if (ng) begin
            foreach (occ[i, j]) occ[i][j] = 1'b0;
            m_cx = 3; m_cy = 3; m_color = 0; m_cnt = 0; m_win = 0; m_busy = 0;
            m_over = 1'b0; m_clr = 1'b0;
        end else if (m_busy == 2) begin
            m_busy = 1;
        end else if (m_busy == 1) begin
            m_busy = 0;
            if (gs != 2'd0) begin m_over = 1'b1; m_win = int'(gs); end
            else if (m_cnt == 49) begin m_over = 1'b1; m_win = 0; end
            else m_color = 1 - m_color;
        end else if (!m_over) begin
            if (e[0]) begin
                it.ex = m_cx; it.ey = m_cy; it.ec = m_color;
                if (occ[m_cx][m_cy]) begin
                    it.is_rej = 1'b1;
                end else begin
                    it.is_rej = 1'b0;
                    occ[m_cx][m_cy] = 1'b1;
                    m_cnt++;
                    m_busy = 2;
                end
                sb.push_back(it);
            end
            if (e[4]) m_cx = (m_cx > 0) ? m_cx - 1 : 0;
            else if (e[3]) m_cx = (m_cx < 6) ? m_cx + 1 : 6;
            if (e[2]) m_cy = (m_cy > 0) ? m_cy - 1 : 0;
            else if (e[1]) m_cy = (m_cy < 6) ? m_cy + 1 : 6;
        end
    endtask

    task automatic check_state(input string name);
        chk(name, {cur_x, cur_y, color, move_count, game_over, winner, board_clr_n},
            {3'(m_cx), 3'(m_cy), 1'(m_color), 6'(m_cnt), m_over, 2'(m_win), m_clr});
    endtask

    // Drive one cycle of inputs (called at posedge+1), advance the model, compare status
    task automatic step(input logic [4:0] b, input logic [1:0] gs, input bit ng);
        {btn_left, btn_right, btn_up, btn_down, btn_place} = b;
        game_state = gs;
        new_game   = ng;
        model_cycle(b, gs, ng);
        @(posedge clk);
        #1;
        check_state("status");
    endtask

    task automatic press(input logic [4:0] b);
        step(b, 2'd0, 1'b0);
        step(5'd0, 2'd0, 1'b0);
    endtask

    task automatic goto_cell(input int tx, input int ty);
        for (int g = 0; g < 16 && m_cx != tx; g++) press(m_cx > tx ? 5'b10000 : 5'b01000);
        for (int g = 0; g < 16 && m_cy != ty; g++) press(m_cy > ty ? 5'b00100 : 5'b00010);
    endtask

    task automatic place_here(input logic [1:0] gs);
        step(5'b00001, 2'd0, 1'b0);
        step(5'd0, 2'd0, 1'b0);
        step(5'd0, gs, 1'b0);
        step(5'd0, 2'd0, 1'b0);
    endtask

    // Monitor: every go/reject presented must match the oldest expected event
    always @(negedge clk) begin
        if (resetn && (go || reject)) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe go=%0d reject=%0d x=%0d y=%0d", go, reject, x, y);
            end else begin
                e = sb.pop_front();
                if (e.is_rej) begin
                    if (!(reject && !go)) begin
                        errors++;
                        $display("FAIL reject_event go=%0d reject=%0d expected reject only", go, reject);
                    end
                end else if (!(go && !reject && x == 3'(e.ex) && y == 3'(e.ey) && color == 1'(e.ec))) begin
                    errors++;
                    $display("FAIL go_event go=%0d rej=%0d x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                             go, reject, x, y, color, e.ex, e.ey, e.ec);
                end
            end
        end
    end

    initial begin
        resetn = 1'b0;
        {btn_left, btn_right, btn_up, btn_down, btn_place, new_game} = 6'd0;
        game_state = 2'd0;
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_outputs", {go, x, y, color, cur_x, cur_y, reject, game_over, winner, move_count, board_clr_n},
            {1'b0, 3'd0, 3'd0, 1'b0, 3'd3, 3'd3, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0});
        resetn = 1'b1;
        step(5'd0, 2'd0, 1'b0);
        chk("clr_release", board_clr_n, 1'b1);

        // Cursor saturation at the far corner
        for (int i = 0; i < 3; i++) press(5'b01000);
        for (int i = 0; i < 5; i++) press(5'b00010);
        chk("cursor_sat", {cur_x, cur_y}, {3'd6, 3'd6});
        press(5'b01000);
        chk("cursor_sat_x", cur_x, 3'd6);
        press(5'b11000);
        chk("left_wins", cur_x, 3'd5);
        press(5'b00110);
        chk("up_wins", cur_y, 3'd5);
        goto_cell(3, 3);

        // First move and a repeated placement on the same cell
        place_here(2'd0);
        chk("first_move", {color, move_count}, {1'b1, 6'd1});
        place_here(2'd0);
        chk("reject_keeps", {color, move_count}, {1'b1, 6'd1});

        // Moves 2..9, black wins on the ninth
        for (int k = 0; k < 8; k++) begin
            goto_cell(k % 7, k / 7);
            place_here(k == 7 ? 2'd1 : 2'd0);
        end
        chk("win_black", {game_over, winner, move_count}, {1'b1, 2'd1, 6'd9});
        press(5'b01000);
        place_here(2'd0);
        chk("locked", {game_over, move_count, cur_x}, {1'b1, 6'd9, 3'd0});

        // Draw on a full board
        step(5'd0, 2'd0, 1'b1);
        chk("ng_clr", board_clr_n, 1'b0);
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7; j++) begin
                goto_cell(i, j);
                place_here(2'd0);
            end
        chk("draw", {game_over, winner, move_count}, {1'b1, 2'd0, 6'd49});

        // new_game cancelling a move in flight
        step(5'd0, 2'd0, 1'b1);
        step(5'd0, 2'd0, 1'b0);
        step(5'b01001, 2'd0, 1'b0);
        step(5'd0, 2'd0, 1'b1);
        chk("ng_issue", {board_clr_n, move_count, color, cur_x, cur_y}, {1'b0, 6'd0, 1'b0, 3'd3, 3'd3});
        step(5'd0, 2'd0, 1'b0);
        chk("ng_issue_rel", board_clr_n, 1'b1);
        place_here(2'd0);
        chk("after_cancel", move_count, 6'd1);

        // Asynchronous reset mid-game, observed between clock edges
        press(5'b10000);
        place_here(2'd0);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_reset", {go, x, y, color, cur_x, cur_y, reject, game_over, winner, move_count, board_clr_n},
            {1'b0, 3'd0, 3'd0, 1'b0, 3'd3, 3'd3, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0});
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        step(5'd0, 2'd0, 1'b0);

        // Randomized play
        for (int c = 0; c < 1500; c++) begin
            logic [4:0] b;
            logic [1:0] gs;
            bit ng;
            b  = ($urandom_range(0, 9) < 5) ? 5'd0 : 5'($urandom_range(0, 31));
            gs = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
            ng = ($urandom_range(0, 299) == 0);
            step(b, gs, ng);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
